// File: rtl/line_fill_engine.sv
// Cache-line fill engine: accepts one miss, reads the line byte by byte
// (critical byte first with wrap), reports the requested byte early, then hands over the line.
module line_fill_engine #(
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int ADDR_W          = 16,
  parameter int MEM_LATENCY     = 1,
  parameter int CRIT_FIRST      = 1
) (
  input  logic                         clk3,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         mem_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [7:0]                   mem_rdata,
  output logic                         crit_valid,
  output logic [7:0]                   crit_data,
  output logic                         fill_valid,
  input  logic                         fill_ready,
  output logic [ADDR_W-1:0]            fill_addr,
  output logic [8*BLOCK_SIZE_BYTE-1:0] fill_block,
  output logic                         busy
);

  localparam int N     = BLOCK_SIZE_BYTE;
  localparam int OFF_W = $clog2(N);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [TAG_W-1:0] r_tag;
  logic [OFF_W-1:0] r_start;
  logic [OFF_W-1:0] r_crit_off;
  logic [OFF_W-1:0] r_issue_cnt;
  logic [OFF_W-1:0] r_cap_cnt;

  logic [MEM_LATENCY-1:0]            r_vld_p;
  logic [MEM_LATENCY-1:0][OFF_W-1:0] r_off_p;

  logic [8*N-1:0] r_fill_block;
  logic           r_crit_valid;
  logic [7:0]     r_crit_data;

  logic             w_accept;
  logic             w_issue;
  logic             w_capture;
  logic [OFF_W-1:0] w_issue_off;
  logic [OFF_W-1:0] w_cap_off;

  assign w_accept    = (r_state == S_IDLE) && req_valid;
  assign w_issue     = (r_state == S_ISSUE);
  assign w_issue_off = r_start + r_issue_cnt;
  assign w_capture   = r_vld_p[MEM_LATENCY-1];
  assign w_cap_off   = r_off_p[MEM_LATENCY-1];

  always_ff @(posedge clk3) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    busy      = 1'b1;
    mem_en    = 1'b0;
    mem_addr  = '0;
    fill_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = {r_tag, w_issue_off};
        if (r_issue_cnt == LAST_OFF) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_capture && (r_cap_cnt == LAST_OFF)) w_next = S_DONE;
      end
      S_DONE: begin
        fill_valid = 1'b1;
        if (fill_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch and issue/capture bookkeeping
  always_ff @(posedge clk3) begin
    if (reset) begin
      r_tag       <= '0;
      r_start     <= '0;
      r_crit_off  <= '0;
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
    end else if (w_accept) begin
      r_tag       <= req_addr[ADDR_W-1:OFF_W];
      r_start     <= (CRIT_FIRST != 0) ? req_addr[OFF_W-1:0] : '0;
      r_crit_off  <= req_addr[OFF_W-1:0];
      r_issue_cnt <= '0;
      r_cap_cnt   <= '0;
    end else begin
      if (w_issue)   r_issue_cnt <= r_issue_cnt + OFF_W'(1);
      if (w_capture) r_cap_cnt   <= r_cap_cnt + OFF_W'(1);
    end
  end

  // Read pipeline: valid/offset travel with each issue until the byte returns
  always_ff @(posedge clk3) begin
    if (reset) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= w_issue;
      for (int i = 1; i < MEM_LATENCY; i++) r_vld_p[i] <= r_vld_p[i-1];
    end
  end

  always_ff @(posedge clk3) begin
    r_off_p[0] <= w_issue_off;
    for (int i = 1; i < MEM_LATENCY; i++) r_off_p[i] <= r_off_p[i-1];
  end

  // Capture stage: placement follows the carried offset, not arrival order
  always_ff @(posedge clk3) begin
    if (reset) begin
      r_fill_block <= '0;
      r_crit_valid <= 1'b0;
      r_crit_data  <= '0;
    end else begin
      r_crit_valid <= w_capture && (w_cap_off == r_crit_off);
      if (w_capture) begin
        r_fill_block[{w_cap_off, 3'b000} +: 8] <= mem_rdata;
        if (w_cap_off == r_crit_off) r_crit_data <= mem_rdata;
      end
    end
  end

  assign fill_block = r_fill_block;
  assign fill_addr  = {r_tag, {OFF_W{1'b0}}};
  assign crit_valid = r_crit_valid;
  assign crit_data  = r_crit_data;

endmodule
